// File: rtl/boton_eventos_pkg.sv
// Shared button definitions: press-tracking state encoding used by the event and mode FSMs.
package boton_eventos_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS    = 2'd1,
        LONG     = 2'd2,
        WAIT_REL = 2'd3
    } boton_estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/boton_eventos.sv
// Turns a debounced button level into press/short/long/repeat pulses plus a held flag.
// All outputs registered: one cycle after the deciding edge; no backpressure, pulses are fire-and-forget.
module boton_eventos
    import boton_eventos_pkg::*;
#(
    parameter int COUNT_LONG = 20,
    parameter int COUNT_REP  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_db,
    input  logic enable,
    output logic pulse_press,
    output logic pulse_short,
    output logic pulse_long,
    output logic pulse_repeat,
    output logic held
);

    localparam int CNT_MAX = max_int(COUNT_LONG, COUNT_REP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(COUNT_LONG - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(COUNT_REP - 1);

    // Declaration initialisers match reset so an unreset simulation starts idle.
    boton_estado_t    estado_q = IDLE;
    boton_estado_t    estado_d;
    logic [CNT_W-1:0] cnt_q    = '0;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q  = 1'b0;
    logic             short_q  = 1'b0;
    logic             long_q   = 1'b0;
    logic             rep_q    = 1'b0;
    logic             held_q   = 1'b0;
    logic             press_d;
    logic             short_d;
    logic             long_d;
    logic             rep_d;
    logic             held_d;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        short_d  = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;

        case (estado_q)
            IDLE: begin
                cnt_d = '0;
                if (enable && boton_db) begin
                    estado_d = PRESS;
                    cnt_d    = CNT_W'(1);
                    press_d  = 1'b1;
                end
            end
            PRESS: begin
                // Disable wins over release so a suppressed press never reports short.
                if (!enable) begin
                    estado_d = WAIT_REL;
                    cnt_d    = '0;
                end else if (!boton_db) begin
                    estado_d = IDLE;
                    cnt_d    = '0;
                    short_d  = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    estado_d = LONG;
                    cnt_d    = '0;
                    long_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (!enable) begin
                    estado_d = WAIT_REL;
                    cnt_d    = '0;
                end else if (!boton_db) begin
                    estado_d = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                    rep_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_REL: begin
                cnt_d = '0;
                if (!boton_db) begin
                    estado_d = IDLE;
                end
            end
            default: begin
                estado_d = IDLE;
                cnt_d    = '0;
            end
        endcase

        held_d = (estado_d == PRESS) || (estado_d == LONG);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            short_q  <= short_d;
            long_q   <= long_d;
            rep_q    <= rep_d;
            held_q   <= held_d;
        end
    end

    assign pulse_press  = press_q;
    assign pulse_short  = short_q;
    assign pulse_long   = long_q;
    assign pulse_repeat = rep_q;
    assign held         = held_q;

endmodule

// File: tb/tb_boton_eventos.sv
// Randomised and scenario stimulus against a press-duration reference model, checked via a scoreboard queue.
module tb_boton_eventos;

    localparam int CL = 20;
    localparam int CR = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic boton_db = 1'b0;
    logic enable = 1'b0;
    logic pulse_press, pulse_short, pulse_long, pulse_repeat, held;

    boton_eventos #(.COUNT_LONG(CL), .COUNT_REP(CR)) dut (
        .clk          (clk),
        .reset        (reset),
        .boton_db     (boton_db),
        .enable       (enable),
        .pulse_press  (pulse_press),
        .pulse_short  (pulse_short),
        .pulse_long   (pulse_long),
        .pulse_repeat (pulse_repeat),
        .held         (held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected output word per cycle: {press, short, long, repeat, held}.
    logic [4:0] exp_q[$];
    bit         running = 1'b0;

    // Reference model: a press is described by how many edges it has been held.
    bit m_tracking = 1'b0;
    bit m_blocked  = 1'b0;
    int m_hold     = 0;
    int exp_cnt[4] = '{0, 0, 0, 0};
    int got_cnt[4] = '{0, 0, 0, 0};

    task automatic model_edge(input logic b, input logic e, input logic r);
        logic [4:0] w;
        w = 5'b0;
        if (r) begin
            m_tracking = 1'b0;
            m_blocked  = 1'b0;
            m_hold     = 0;
        end else if (m_tracking) begin
            if (!e) begin
                m_tracking = 1'b0;
                m_blocked  = 1'b1;
            end else if (!b) begin
                if (m_hold < CL) w[3] = 1'b1;
                m_tracking = 1'b0;
            end else begin
                m_hold = m_hold + 1;
                if (m_hold == CL) w[2] = 1'b1;
                else if (m_hold > CL && ((m_hold - CL) % CR) == 0) w[1] = 1'b1;
            end
        end else if (m_blocked) begin
            if (!b) m_blocked = 1'b0;
        end else if (e && b) begin
            m_tracking = 1'b1;
            m_hold     = 1;
            w[4]       = 1'b1;
        end
        w[0] = m_tracking;
        for (int i = 0; i < 4; i++) exp_cnt[i] += w[4-i];
        exp_q.push_back(w);
    endtask

    task automatic step(input logic b, input logic e, input logic r);
        boton_db = b;
        enable   = e;
        reset    = r;
        model_edge(b, e, r);
        @(posedge clk);
        #1;
    endtask

    task automatic hold_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: compares whatever the DUT shows against the oldest expectation.
    initial begin : monitor
        int cyc;
        logic [4:0] want;
        logic [4:0] got;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() == 0) begin
                if (running) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow cyc=%0d got=empty want=entry", cyc);
                end
            end else begin
                want = exp_q.pop_front();
                got  = {pulse_press, pulse_short, pulse_long, pulse_repeat, held};
                for (int i = 0; i < 4; i++) got_cnt[i] += int'(got[4-i]);
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got press/short/long/rep/held=%b want=%b", cyc, got, want);
                end
                total++;
                if (!$onehot0(got[4:1])) begin
                    bad++;
                    $display("FAIL single_pulse cyc=%0d got pulses=%b want at most one set", cyc, got[4:1]);
                end
            end
        end
    end

    initial begin : stim
        bit b, e;
        #1;
        total++;
        if ({pulse_press, pulse_short, pulse_long, pulse_repeat, held} !== 5'b0) begin
            bad++;
            $display("FAIL initial_state got=%b want=00000",
                     {pulse_press, pulse_short, pulse_long, pulse_repeat, held});
        end
        running = 1'b1;

        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        idle_n(3);

        hold_n(5);   idle_n(4);             // short press
        hold_n(19);  idle_n(4);             // just below long
        hold_n(20);  idle_n(4);             // exactly long
        hold_n(45);  idle_n(6);             // long with three repeats

        hold_n(10);                         // enable drop while held
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        hold_n(15);
        idle_n(3);
        hold_n(6);   idle_n(3);

        hold_n(25);                         // reset mid-LONG, button still down
        step(1'b1, 1'b1, 1'b1);
        hold_n(6);   idle_n(3);

        step(1'b1, 1'b0, 1'b0);             // held in IDLE while disabled
        step(1'b1, 1'b0, 1'b0);
        hold_n(3);   idle_n(3);

        b = 1'b0;
        e = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) b = ~b;
            if (e) begin
                if ($urandom_range(0, 59) == 0) e = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                e = 1'b1;
            end
            step(b, e, ($urandom_range(0, 299) == 0));
        end
        idle_n(2);

        running = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d left want=0", exp_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_cnt[i] != exp_cnt[i]) begin
                bad++;
                $display("FAIL pulse_total kind=%0d got=%0d want=%0d", i, got_cnt[i], exp_cnt[i]);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boton_eventos.md
BOTON_EVENTOS -- requirements
Module: boton_eventos

Interface
REQ-001 SHALL have parameter COUNT_LONG, default 20 (sim; 50_000_000 on board), meaning the held-sample count that qualifies a long press; legal range >= 2.
REQ-002 SHALL have parameter COUNT_REP, default 8 (sim; 10_000_000 on board), meaning the auto-repeat period in cycles while long-held; legal range >= 1.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port boton_db, input, 1 bit: debounced button level, 1 = pressed, already synchronous to clk.
REQ-006 SHALL have port enable, input, 1 bit: event generation allowed.
REQ-007 SHALL have port pulse_press, output reg, 1 bit: one-cycle pulse on press start.
REQ-008 SHALL have port pulse_short, output reg, 1 bit: one-cycle pulse on release before long qualification.
REQ-009 SHALL have port pulse_long, output reg, 1 bit: one-cycle pulse when hold reaches COUNT_LONG samples.
REQ-010 SHALL have port pulse_repeat, output reg, 1 bit: one-cycle pulse every COUNT_REP cycles after pulse_long while held.
REQ-011 SHALL have port held, output reg, 1 bit: high while in PRESS or LONG.

Function
REQ-012 SHALL implement states IDLE, PRESS, LONG, WAIT_REL, with one counter cnt of width $clog2(max(COUNT_LONG,COUNT_REP)+1).
REQ-013 SHALL register all outputs; each pulse_* SHALL be high for exactly one cycle per event and SHALL be 0 by default every cycle.
REQ-014 IDLE, enable=1, boton_db=1 at edge k: go to PRESS, set cnt<=1, assert pulse_press and held during cycle k+1.
REQ-015 PRESS, boton_db=0: assert pulse_short, go to IDLE, set cnt<=0; release SHALL take priority over long qualification on the same edge.
REQ-016 PRESS, boton_db=1, cnt==COUNT_LONG-1: assert pulse_long, go to LONG, set cnt<=0, so pulse_long is visible in cycle k+COUNT_LONG; otherwise increment cnt.
REQ-017 LONG, boton_db=1: if cnt==COUNT_REP-1, assert pulse_repeat and set cnt<=0; else increment cnt; first repeat SHALL come COUNT_REP cycles after pulse_long.
REQ-018 LONG, boton_db=0: go to IDLE with no pulse; pulse_short SHALL never follow pulse_long for the same press.
REQ-019 enable=0 in PRESS or LONG: go to WAIT_REL, set cnt<=0, clear held, emit no pulse; enable=0 in IDLE: stay IDLE.
REQ-020 WAIT_REL: stay until boton_db=0, then go to IDLE; a button held across an enable drop SHALL NOT generate a new press.
REQ-021 cnt SHALL never exceed max(COUNT_LONG,COUNT_REP)-1 and SHALL never wrap.
REQ-022 At most one pulse_* SHALL be high in any cycle.

Reset
REQ-023 reset=1 at a clock edge SHALL force state to IDLE, cnt to 0, and all outputs to 0, overriding every other condition, including mid-PRESS or mid-LONG.
REQ-024 initial values SHALL equal the reset values so simulation without reset is defined.
REQ-025 After reset, boton_db=1 SHALL be treated as a new press at the next edge with enable=1.

Structure
REQ-026 The state encodings (2-bit: IDLE=0, PRESS=1, LONG=2, WAIT_REL=3) SHALL live in the shared botones definitions header, for use by the mode FSM.
REQ-027 The block SHALL be a single module with no sub-module; one instance per debounced button.

Verification (COUNT_LONG=20, COUNT_REP=8)
REQ-028 Press for 5 cycles then release -> pulse_press at cycle k+1, then pulse_short once, and no pulse_long.
REQ-029 Press for 19 samples then release -> pulse_short; press for 20 samples -> pulse_long at cycle k+20 and no pulse_short.
REQ-030 Hold for 45 cycles -> pulse_long at k+20, then pulse_repeat at k+28, k+36, k+44; release -> no further pulses.
REQ-031 Drop enable at k+10 while held, restore it at k+15, release at k+30 -> no pulses after pulse_press and held=0 from k+11; next press works normally.
REQ-032 Assert reset at k+25 while in LONG -> all outputs 0 the next cycle; with boton_db still 1 and enable=1, a new pulse_press follows after reset drops.
